// File: rtl/spi_rx_deser_pkg.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_pkg
// Description : Shared types and helpers for the SPI receive path.
//               - state_t     : receiver FSM encoding (IDLE / SHIFT)
//               - SAMPLE_RISE / SAMPLE_FALL : sampling-edge selectors
//               - clog2()     : constant-function width helper
// Revision    : 1.0 - initial release
// ============================================================================
package spi_rx_pkg;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    localparam bit SAMPLE_RISE = 1'b1;
    localparam bit SAMPLE_FALL = 1'b0;

    // Smallest width able to index 'value' distinct codes.
    function automatic int unsigned clog2(input int unsigned value);
        int unsigned result;
        result = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < {32'd0, value}) begin
                result = i + 1;
            end
        end
        return result;
    endfunction

endpackage : spi_rx_pkg
`default_nettype wire

// File: rtl/spi_rx_deser_if.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_deser_if
// Description : Received-byte port of the SPI deserialiser.
//               rx_data/rx_valid/rx_ready form a valid/ready handshake;
//               overrun and frame_err are one-cycle event pulses; busy is a
//               level that is high while a frame is being shifted in.
//               master : producer side (the deserialiser)
//               slave  : consumer side
// Revision    : 1.0 - initial release
// ============================================================================
interface spi_rx_deser_if #(
    parameter int unsigned DATA_W = 8
);

    logic [DATA_W-1:0] rx_data;
    logic              rx_valid;
    logic              rx_ready;
    logic              overrun;
    logic              frame_err;
    logic              busy;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        output overrun,
        output frame_err,
        output busy
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        input  overrun,
        input  frame_err,
        input  busy
    );

endinterface : spi_rx_deser_if
`default_nettype wire

// File: rtl/spi_rx_deser_sync_edge.sv
`default_nettype none
// ============================================================================
// Module      : spi_sync_edge
// Description : Brings an external serial clock/data pair into clk_i through
//               SYNC_STAGES-deep synchronisers and edge-detects the clock.
//               Both paths use the same depth so data stays aligned with the
//               clock edge that qualifies it.
// Ports       : clk_i    - system clock
//               rst_ni   - asynchronous active-low reset
//               sclk_i   - external serial clock (idles low)
//               sdata_i  - external serial data
//               data_s_o - synchronised data
//               rise_o   - synchronised serial clock rose this cycle
//               fall_o   - synchronised serial clock fell this cycle
// Revision    : 1.0 - initial release
// ============================================================================
module spi_sync_edge #(
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic sclk_i,
    input  logic sdata_i,
    output logic data_s_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] clk_sync_q;
    logic [SYNC_STAGES-1:0] data_sync_q;
    logic                   clk_prev_q;

    // Clearing to 0 matches the idle-low serial clock, so no edge is
    // reported when reset is released with the line idle.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            clk_sync_q  <= '0;
            data_sync_q <= '0;
            clk_prev_q  <= 1'b0;
        end else begin
            clk_sync_q  <= {clk_sync_q[SYNC_STAGES-2:0], sclk_i};
            data_sync_q <= {data_sync_q[SYNC_STAGES-2:0], sdata_i};
            clk_prev_q  <= clk_sync_q[SYNC_STAGES-1];
        end
    end

    assign data_s_o = data_sync_q[SYNC_STAGES-1];
    assign rise_o   =  clk_sync_q[SYNC_STAGES-1] & ~clk_prev_q;
    assign fall_o   = ~clk_sync_q[SYNC_STAGES-1] &  clk_prev_q;

endmodule : spi_sync_edge
`default_nettype wire

// File: rtl/spi_rx_deser.sv
`default_nettype none
// ============================================================================
// Module      : spi_rx_deser
// Description : SPI (MOSI) serial-to-parallel receiver. Rebuilds DATA_W-bit
//               frames MSB first from an asynchronous spi_clk/spi_data pair,
//               presents them on a valid/ready port, drops partial frames
//               after TIMEOUT idle cycles (frame_err) and flags completed
//               frames that find the holding register full (overrun).
// Ports       : clk_i      - system clock
//               rst_ni     - asynchronous active-low reset
//               spi_clk_i  - serial clock from the transmitter (idles low)
//               spi_data_i - serial data (MOSI)
//               rx         - received-byte port (master side); the interface
//                            DATA_W must equal this module's DATA_W
// Revision    : 1.0 - initial release
// ============================================================================
module spi_rx_deser
    import spi_rx_pkg::*;
#(
    parameter int unsigned DATA_W      = 8,
    parameter int unsigned SYNC_STAGES = 2,
    parameter int unsigned TIMEOUT     = 64,
    parameter bit          SAMPLE_EDGE = SAMPLE_RISE
) (
    input  logic           clk_i,
    input  logic           rst_ni,
    input  logic           spi_clk_i,
    input  logic           spi_data_i,
    spi_rx_deser_if.master rx
);

    localparam int unsigned CNT_W = clog2(DATA_W + 1);
    localparam int unsigned TMO_W = clog2(TIMEOUT);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DATA_W - 1);
    localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);

    // ------------------------------------------------------------------
    // Synchronise and edge-detect
    // ------------------------------------------------------------------
    logic w_data_s;
    logic w_rise;
    logic w_fall;
    logic w_sample;
    logic w_any_edge;

    spi_sync_edge #(
        .SYNC_STAGES (SYNC_STAGES)
    ) u_sync_edge (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .sclk_i   (spi_clk_i),
        .sdata_i  (spi_data_i),
        .data_s_o (w_data_s),
        .rise_o   (w_rise),
        .fall_o   (w_fall)
    );

    generate
        if (SAMPLE_EDGE == SAMPLE_RISE) begin : g_sample_rise
            assign w_sample = w_rise;
        end else begin : g_sample_fall
            assign w_sample = w_fall;
        end
    endgenerate

    // Either edge proves the transmitter is still alive.
    assign w_any_edge = w_rise | w_fall;

    // ------------------------------------------------------------------
    // Frame FSM
    // ------------------------------------------------------------------
    state_t            state_q;
    logic [CNT_W-1:0]  bit_cnt_q;
    logic [TMO_W-1:0]  tmo_q;
    logic [DATA_W-1:0] shift_q;
    logic [DATA_W-1:0] shift_d;
    logic [DATA_W-1:0] first_d;
    logic              done_q;
    logic              frame_err_q;
    logic              busy_q;

    assign shift_d = {shift_q[DATA_W-2:0], w_data_s};
    assign first_d = {{(DATA_W-1){1'b0}}, w_data_s};

    // done_q marks the cycle after the completing sample; shift_q holds the
    // finished frame during that cycle for the holding register to pick up.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            bit_cnt_q   <= '0;
            tmo_q       <= '0;
            shift_q     <= '0;
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            done_q      <= 1'b0;
            frame_err_q <= 1'b0;
            case (state_q)
                IDLE: begin
                    tmo_q <= '0;
                    if (w_sample) begin
                        shift_q   <= first_d;
                        bit_cnt_q <= CNT_W'(1);
                        state_q   <= SHIFT;
                        busy_q    <= 1'b1;
                    end
                end
                SHIFT: begin
                    if (w_sample && (bit_cnt_q == CNT_LAST)) begin
                        // Completion takes priority over a coincident timeout.
                        shift_q   <= shift_d;
                        bit_cnt_q <= '0;
                        tmo_q     <= '0;
                        done_q    <= 1'b1;
                        state_q   <= IDLE;
                        busy_q    <= 1'b0;
                    end else begin
                        if (w_sample) begin
                            shift_q   <= shift_d;
                            bit_cnt_q <= bit_cnt_q + 1'b1;
                        end
                        if (w_any_edge) begin
                            tmo_q <= '0;
                        end else if (tmo_q == TMO_LAST) begin
                            frame_err_q <= 1'b1;
                            shift_q     <= '0;
                            bit_cnt_q   <= '0;
                            tmo_q       <= '0;
                            state_q     <= IDLE;
                            busy_q      <= 1'b0;
                        end else begin
                            tmo_q <= tmo_q + 1'b1;
                        end
                    end
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Holding register and valid/ready handshake
    // ------------------------------------------------------------------
    logic [DATA_W-1:0] rx_data_q;
    logic              rx_valid_q;
    logic              overrun_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            overrun_q  <= 1'b0;
        end else begin
            overrun_q <= 1'b0;
            if (done_q) begin
                // A consumer accepting in this same cycle frees the slot.
                if (!rx_valid_q || rx.rx_ready) begin
                    rx_data_q  <= shift_q;
                    rx_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rx_valid_q && rx.rx_ready) begin
                rx_valid_q <= 1'b0;
            end
        end
    end

    assign rx.rx_data   = rx_data_q;
    assign rx.rx_valid  = rx_valid_q;
    assign rx.overrun   = overrun_q;
    assign rx.frame_err = frame_err_q;
    assign rx.busy      = busy_q;

endmodule : spi_rx_deser
`default_nettype wire
